mod3_check_scheduler: RTL and testbench

Shares one serial divisible-by-3 residue engine between two parallel-word requesters. Each accepted WIDTH-bit word is shifted into the engine MSB-first, one bit per clock. The verdict is returned with the requester's ID over a valid/ready result port. The block sits between the bus-side producers and the serial mod-3 datapath, and owns arbitration, serialization and engine clearing.

---
 rtl/mod3_sched_pkg.sv | 30 +++
 rtl/mod3_check_scheduler_if.sv | 26 ++
 rtl/mod3_residue.sv | 26 ++
 rtl/mod3_check_scheduler.sv | 115 +++++++++++
 tb/tb_mod3_check_scheduler.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mod3_sched_pkg.sv
// Shared types and constants for the mod-3 check scheduler.
// The residue step function is the single definition of the (2r + b) mod 3 recurrence.
package mod3_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    // Residue 3 is unreachable; it is folded back to R0 so a corrupted state self-heals.
    function automatic logic [1:0] residue_step(input logic [1:0] r, input logic b);
        logic [1:0] nxt;
        case (r)
            R0:      nxt = b ? R1 : R0;
            R1:      nxt = b ? R0 : R2;
            R2:      nxt = b ? R2 : R1;
            default: nxt = R0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod3_check_scheduler_if.sv
// Request/result bundle between the two word producers, the scheduler and the result consumer.
// master = producers/consumer side, slave = scheduler side.
interface mod3_check_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             res_valid;
    logic             res_div;
    logic             res_id;
    logic             res_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_div, res_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_div, res_id
    );
endinterface

// File: rtl/mod3_residue.sv
// Serial divisible-by-3 engine: consumes one bit per enabled clock, MSB-first.
// Clear wins over enable so a new word never inherits a stale residue.
module mod3_residue
    import mod3_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] residue,
    output logic       div
);

    // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            residue <= R0;
        end else if (en) begin
            residue <= residue_step(residue, bit_in);
        end
    end

    assign div = (residue == R0);

endmodule

// File: rtl/mod3_check_scheduler.sv
// Round-robin arbiter, serializer and result register in front of the shared mod-3 engine.
// One word is in flight at a time: accept in IDLE, shift WIDTH bits, hold the verdict in DONE.
module mod3_check_scheduler
    import mod3_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mod3_check_scheduler_if.slave bus,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             last_grant;
    logic             cur_id;
    logic             grant;
    logic             accept;
    logic             res_valid_q;
    logic             res_div_q;
    logic             res_id_q;
    logic [1:0]       eng_residue;
    logic             unused_eng_div;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant = ID0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = (last_grant == ID0) ? ID1 : ID0;
        end else if (bus.req1_valid) begin
            grant = ID1;
        end
    end

    assign accept = (state == IDLE) && !rst &&
                    ((grant == ID0) ? bus.req0_valid : bus.req1_valid);

    assign bus.req0_ready = accept && (grant == ID0);
    assign bus.req1_ready = accept && (grant == ID1);

    // NOTE: the shift register is pure datapath, always loaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= (grant == ID0) ? bus.req0_data : bus.req1_data;
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
        end
    end

    mod3_residue u_engine (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state == SHIFT),
        .bit_in  (shreg[WIDTH-1]),
        .residue (eng_residue),
        .div     (unused_eng_div)
    );

    // The verdict is captured on the same edge as the last bit, from the engine's next residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= ID1;
            cur_id      <= ID0;
            res_valid_q <= 1'b0;
            res_div_q   <= 1'b0;
            res_id_q    <= ID0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SHIFT;
                        busy       <= 1'b1;
                        cnt        <= CW'(WIDTH);
                        last_grant <= grant;
                        cur_id     <= grant;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                        res_div_q   <= (residue_step(eng_residue, shreg[WIDTH-1]) == R0);
                        res_id_q    <= cur_id;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_div   = res_div_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_mod3_check_scheduler.sv
// Directed bench for mod3_check_scheduler (WIDTH=8): reset, single words, edge values,
// contention, backpressure and reset mid-shift, with hand-computed verdicts.
module tb_mod3_check_scheduler;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    logic busy;
    int   n_asserts;
    int   n_fail;

    mod3_check_scheduler_if #(.WIDTH(WIDTH)) bus ();

    mod3_check_scheduler #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.res_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Present a word, wait (bounded) for its grant, then check latency and verdict and retire it.
    task automatic send_word(input logic id, input logic [7:0] data, input logic exp_div,
                             input string tag);
        int lat;
        logic rdy;
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = data;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = data;
        end
        #1;
        rdy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rdy = id ? bus.req1_ready : bus.req0_ready;
            if (rdy === 1'b1) break;
            tick();
        end
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        tick();
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_div"}, 32'(bus.res_div), 32'(exp_div));
        check({tag, "_id"}, 32'(bus.res_id), 32'(id));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_idle"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        n_asserts      = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hD3;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h55;
        bus.res_ready  = 1'b0;

        // Reset held 3 cycles with both valids high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_r0", 32'(bus.req0_ready), 32'd0);
            check("rst_r1", 32'(bus.req1_ready), 32'd0);
            check("rst_rv", 32'(bus.res_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_div", 32'(bus.res_div), 32'd0);
        check("rst_id", 32'(bus.res_id), 32'd0);
        rst = 1'b0;
        #1;
        check("tie0_r0", 32'(bus.req0_ready), 32'd1);
        check("tie0_r1", 32'(bus.req1_ready), 32'd0);
        bus.req1_valid = 1'b0;

        // Single words from req0: 211 mod 3 = 1, 195 mod 3 = 0.
        send_word(1'b0, 8'hD3, 1'b0, "w_d3");
        send_word(1'b0, 8'hC3, 1'b1, "w_c3");

        // Edge values, alternating requesters so req1 is served last.
        send_word(1'b0, 8'h00, 1'b1, "w_00");
        send_word(1'b1, 8'hFF, 1'b1, "w_ff");
        send_word(1'b0, 8'h80, 1'b0, "w_80");
        send_word(1'b1, 8'h01, 1'b0, "w_01");

        // Contention: 180 (div) from req0, then 11 (not div) from req1.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hB4;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h0B;
        #1;
        check("cont_r0", 32'(bus.req0_ready), 32'd1);
        check("cont_r1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        check("cont_shift_r1", 32'(bus.req1_ready), 32'd0);
        wait_result(lat);
        check("cont_lat", 32'(lat), 32'd8);
        check("cont_div0", 32'(bus.res_div), 32'd1);
        check("cont_id0", 32'(bus.res_id), 32'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        send_word(1'b1, 8'h0B, 1'b0, "cont_w1");

        // Re-raise both: req0 must win; then hold its result under backpressure.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h06;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h07;
        #1;
        check("rr_r0", 32'(bus.req0_ready), 32'd1);
        check("rr_r1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rv", 32'(bus.res_valid), 32'd1);
            check("bp_div", 32'(bus.res_div), 32'd1);
            check("bp_id", 32'(bus.res_id), 32'd0);
            check("bp_r1", 32'(bus.req1_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_busy", 32'(busy), 32'd0);
        check("bp_rv_off", 32'(bus.res_valid), 32'd0);
        check("bp_next_r1", 32'(bus.req1_ready), 32'd1);
        send_word(1'b1, 8'h07, 1'b0, "bp_w1");

        // Reset after 4 bits of 0xFF: word is dropped, engine starts clean for 0x03.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hFF;
        #1;
        check("ab_r0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("ab_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.res_valid === 1'b1) seen++;
        end
        check("ab_no_res", 32'(seen), 32'd0);
        send_word(1'b0, 8'h03, 1'b1, "ab_w03");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
